spu_byte_pipe: RTL

//  Pipelined SPU byte execution unit: AVGB, ABSDB, SUMB, CNTB on 128-bit operands.

---
 rtl/spu_pkg.sv | 32 +++
 rtl/spu_byte_lane.sv | 33 +++
 rtl/spu_byte_pipe.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/spu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spu_pkg
// Purpose : Shared types and opcode constants for the SPU byte execution unit.
//           Opcode values are also consumed by the decode stage.
// Contents: byte_op_e (AVGB/ABSDB/SUMB/CNTB), opcode localparams, quad_t
// Revision: 1.0 - initial release
// ============================================================================
package spu_pkg;

  typedef enum logic [1:0] {
    AVGB  = 2'd0,
    ABSDB = 2'd1,
    SUMB  = 2'd2,
    CNTB  = 2'd3
  } byte_op_e;

  // Raw opcode encodings for decode logic that works on plain bit fields.
  localparam logic [1:0] C_OP_AVGB  = 2'd0;
  localparam logic [1:0] C_OP_ABSDB = 2'd1;
  localparam logic [1:0] C_OP_SUMB  = 2'd2;
  localparam logic [1:0] C_OP_CNTB  = 2'd3;

  localparam int C_QUAD_W = 128;
  localparam int C_BYTES  = 16;
  localparam int C_HALVES = 8;
  localparam int C_WORDS  = 4;

  typedef logic [127:0] quad_t;

endpackage
`default_nettype wire

// File: rtl/spu_byte_lane.sv
`default_nettype none
// ============================================================================
// Module  : spu_byte_lane
// Purpose : Combinational per-byte arithmetic for one of the 16 byte lanes.
// Ports   : a, b  - unsigned operand bytes (RA, RB)
//           avg   - rounded-up average (a + b + 1) >> 1
//           absd  - |b - a|
//           pop   - population count of a (0..8)
// Revision: 1.0 - initial release
// ============================================================================
module spu_byte_lane (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] avg,
  output logic [7:0] absd,
  output logic [3:0] pop
);

  // 9-bit sum so the carry out is retained before the halving shift.
  assign avg  = 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);

  // Subtract the smaller from the larger so the result never wraps.
  assign absd = (a >= b) ? (a - b) : (b - a);

  always_comb begin
    pop = 4'd0;
    for (int k = 0; k < 8; k++) begin
      pop = pop + 4'(a[k]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spu_byte_pipe.sv
`default_nettype none
// ============================================================================
// Module  : spu_byte_pipe
// Purpose : Two-stage pipelined SPU byte unit (AVGB, ABSDB, SUMB, CNTB) on
//           128-bit operands with valid/ready flow control on both sides.
//           S1 registers per-byte results and halfword pair sums; S2 finishes
//           the SUMB adds, selects by opcode and drives the outputs.
// Ports   : clk, rst_n            - clock, async active-low reset
//           in_valid/in_ready     - issue handshake
//           in_op, in_ra, in_rb   - opcode and operands
//           in_rt                 - destination tag
//           flush                 - drop every in-flight operation
//           out_valid/out_ready   - writeback handshake
//           out_rt, out_data      - result tag and data (held when idle)
//           busy                  - any stage holds a valid op
// Revision: 1.0 - initial release
// ============================================================================
module spu_byte_pipe
  import spu_pkg::*;
#(
  parameter int TAG_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  byte_op_e         in_op,
  input  logic [127:0]     in_ra,
  input  logic [127:0]     in_rb,
  input  logic [TAG_W-1:0] in_rt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_rt,
  output logic [127:0]     out_data,
  output logic             busy
);

  // --------------------------------------------------------------------------
  // Stage-0 combinational: byte lanes and halfword pair sums
  // --------------------------------------------------------------------------
  quad_t             w_avg;
  quad_t             w_absd;
  logic [63:0]       w_pop;
  logic [7:0][8:0]   w_pair_a;
  logic [7:0][8:0]   w_pair_b;

  for (genvar j = 0; j < C_BYTES; j++) begin : g_lane
    spu_byte_lane u_lane (
      .a    (in_ra[8*j +: 8]),
      .b    (in_rb[8*j +: 8]),
      .avg  (w_avg[8*j +: 8]),
      .absd (w_absd[8*j +: 8]),
      .pop  (w_pop[4*j +: 4])
    );
  end

  for (genvar h = 0; h < C_HALVES; h++) begin : g_pair
    assign w_pair_a[h] = {1'b0, in_ra[16*h +: 8]} + {1'b0, in_ra[16*h+8 +: 8]};
    assign w_pair_b[h] = {1'b0, in_rb[16*h +: 8]} + {1'b0, in_rb[16*h+8 +: 8]};
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_adv;
  logic w_accept;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv && !flush;
  assign w_accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // S1 registers
  // --------------------------------------------------------------------------
  logic             r_s1_valid;
  byte_op_e         r_s1_op;
  logic [TAG_W-1:0] r_s1_rt;
  quad_t            r_s1_avg;
  quad_t            r_s1_absd;
  logic [63:0]      r_s1_pop;
  logic [7:0][8:0]  r_s1_pair_a;
  logic [7:0][8:0]  r_s1_pair_b;

  // --------------------------------------------------------------------------
  // S2 combinational: SUMB word adds, CNTB zero-extension, op select
  // --------------------------------------------------------------------------
  quad_t w_sumb;
  quad_t w_cntb;
  quad_t w_result;

  for (genvar i = 0; i < C_WORDS; i++) begin : g_word
    logic [9:0] w_sum_a;
    logic [9:0] w_sum_b;
    assign w_sum_a = {1'b0, r_s1_pair_a[2*i]} + {1'b0, r_s1_pair_a[2*i+1]};
    assign w_sum_b = {1'b0, r_s1_pair_b[2*i]} + {1'b0, r_s1_pair_b[2*i+1]};
    // RB sum in the upper halfword, RA sum in the lower.
    assign w_sumb[32*i +: 32] = {6'd0, w_sum_b, 6'd0, w_sum_a};
  end

  for (genvar j = 0; j < C_BYTES; j++) begin : g_cnt
    assign w_cntb[8*j +: 8] = {4'd0, r_s1_pop[4*j +: 4]};
  end

  always_comb begin
    w_result = '0;
    case (r_s1_op)
      AVGB:    w_result = r_s1_avg;
      ABSDB:   w_result = r_s1_absd;
      SUMB:    w_result = w_sumb;
      CNTB:    w_result = w_cntb;
      default: w_result = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pipeline state
  // --------------------------------------------------------------------------
  logic             r_out_valid;
  logic [TAG_W-1:0] r_out_rt;
  quad_t            r_out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= AVGB;
      r_s1_rt     <= '0;
      r_s1_avg    <= '0;
      r_s1_absd   <= '0;
      r_s1_pop    <= '0;
      r_s1_pair_a <= '0;
      r_s1_pair_b <= '0;
      r_out_valid <= 1'b0;
      r_out_rt    <= '0;
      r_out_data  <= '0;
    end else begin
      // Flush wins over a stall: both valid bits drop regardless of adv.
      if (flush) begin
        r_s1_valid  <= 1'b0;
        r_out_valid <= 1'b0;
      end else if (w_adv) begin
        r_s1_valid  <= w_accept;
        r_out_valid <= r_s1_valid;
      end

      // Data registers load only with a live op so the outputs keep the
      // last delivered result while idle.
      if (w_accept) begin
        r_s1_op     <= in_op;
        r_s1_rt     <= in_rt;
        r_s1_avg    <= w_avg;
        r_s1_absd   <= w_absd;
        r_s1_pop    <= w_pop;
        r_s1_pair_a <= w_pair_a;
        r_s1_pair_b <= w_pair_b;
      end

      if (w_adv && r_s1_valid && !flush) begin
        r_out_rt   <= r_s1_rt;
        r_out_data <= w_result;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_rt    = r_out_rt;
  assign out_data  = r_out_data;
  assign busy      = r_s1_valid || r_out_valid;

endmodule
`default_nettype wire
